// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin arbitrating multiplexer:
// arbiter state encoding and the index-width helpers used by every
// parametrised block in this slice.
package rr_mux_pkg;

    // Arbiter state: ARB picks a new winner each beat, BURST holds the grant.
    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Channel-index width: never narrower than one bit so N=1 still has a port.
    function automatic int cw_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N upstream producers and one downstream consumer.
// The arbiter takes the slave view; whoever drives the producers and the
// consumer takes the master view.
interface rr_mux_arb_if
    import rr_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16
) ();

    localparam int CW = cw_of(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [CW-1:0]      out_chan;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data,
        input  in_last,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_last,
        output out_chan,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_last,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_last,
        input  out_chan,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/rr_mux_arb_pick.sv
// Combinational round-robin picker: returns the first requesting channel at or
// after ptr, wrapping modulo N. The request vector is doubled and shifted so
// the search always starts at bit 0 of the rotated copy.
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = cw_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic          any,
    output logic [CW-1:0] idx
);

    logic [N-1:0]  rot_s;
    logic [CW-1:0] off_s;
    logic [CW:0]   sum_s;

    // Rotate requests so ptr lands on bit 0, find the lowest set bit, undo the rotation.
    always_comb begin
        rot_s = N'({req, req} >> ptr);
        off_s = '0;
        for (int j = N - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? CW'(j) : off_s;
        end
        any   = |rot_s;
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        idx   = (sum_s >= (CW+1)'(N)) ? CW'(sum_s - (CW+1)'(N)) : sum_s[CW-1:0];
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel registered multiplexer with round-robin arbitration and burst
// locking. A grant taken on a non-last beat is held until that channel's last
// beat; the pointer then advances past the finishing channel so the next
// winner can be accepted on the very next cycle.
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_arb_if.slave bus
);

    localparam int CW = cw_of(N);

    arb_state_t       state_r;
    logic [CW-1:0]    ptr_r;
    logic [CW-1:0]    gnt_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic [CW-1:0]    out_chan_r;
    logic             out_valid_r;

    logic             any_s;
    logic [CW-1:0]    win_s;
    logic [CW-1:0]    g_s;
    logic             grant_ok_s;
    logic             can_take_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_last_s;
    logic             sel_valid_s;
    logic             accept_s;
    logic [N-1:0]     in_ready_s;
    logic [CW:0]      nxt_wide_s;
    logic [CW-1:0]    nxt_ptr_s;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req (bus.in_valid),
        .ptr (ptr_r),
        .any (any_s),
        .idx (win_s)
    );

    // Effective grant: the picker's winner while arbitrating, the locked channel mid-burst.
    always_comb begin
        g_s        = win_s;
        grant_ok_s = any_s;
        case (state_r)
            ARB: begin
                g_s        = win_s;
                grant_ok_s = any_s;
            end
            BURST: begin
                g_s        = gnt_r;
                grant_ok_s = 1'b1;
            end
            default: begin
                g_s        = '0;
                grant_ok_s = 1'b0;
            end
        endcase
    end

    // Route the granted channel's beat and raise only that channel's ready.
    always_comb begin
        sel_data_s  = '0;
        sel_last_s  = 1'b0;
        sel_valid_s = 1'b0;
        in_ready_s  = '0;
        can_take_s  = ~out_valid_r | bus.out_ready;
        for (int i = 0; i < N; i++) begin
            if (g_s == CW'(i)) begin
                sel_data_s    = bus.in_data[i*WIDTH +: WIDTH];
                sel_last_s    = bus.in_last[i];
                sel_valid_s   = bus.in_valid[i];
                in_ready_s[i] = grant_ok_s & can_take_s & rst_n;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
        accept_s = sel_valid_s & grant_ok_s & can_take_s;
    end

    // Pointer for the next arbitration: one past the channel that just finished.
    always_comb begin
        nxt_wide_s = {1'b0, g_s} + {{CW{1'b0}}, 1'b1};
        if (nxt_wide_s >= (CW+1)'(N)) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = nxt_wide_s[CW-1:0];
        end
    end

    // Arbiter FSM, grant/pointer bookkeeping and the output beat register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB;
            ptr_r       <= '0;
            gnt_r       <= '0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_chan_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                out_data_r  <= sel_data_s;
                out_last_r  <= sel_last_s;
                out_chan_r  <= g_s;
                out_valid_r <= 1'b1;
                case (state_r)
                    ARB, BURST: begin
                        if (sel_last_s) begin
                            state_r <= ARB;
                            ptr_r   <= nxt_ptr_s;
                        end else begin
                            state_r <= BURST;
                            gnt_r   <= g_s;
                        end
                    end
                    default: begin
                        state_r <= ARB;
                    end
                endcase
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_chan  = out_chan_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: a 4x16 instance driven by directed and random beats
// against a transaction-level model, and a 1x8 instance streaming 0..255
// under random backpressure against an in-order scoreboard.
module tb_rr_mux_arb;
    import rr_mux_pkg::*;

    localparam int N4 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_mux_arb_if #(.N(4), .WIDTH(16)) bus4 ();
    rr_mux_arb_if #(.N(1), .WIDTH(8))  bus1 ();

    rr_mux_arb #(.WIDTH(16), .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    rr_mux_arb #(.WIDTH(8),  .N(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the 4-channel arbiter: who holds a burst lock, where the
    // round-robin search starts, and what the output register shows.
    bit          m_lock;
    int          m_gnt;
    int          m_ptr;
    bit          m_ov;
    bit          m_ol;
    logic [15:0] m_od;
    int          m_oc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0; m_gnt = 0; m_ptr = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_od = 16'h0000; m_oc = 0;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] d, input logic l, input logic v);
        bus4.in_data[ch*16 +: 16] = d;
        bus4.in_last[ch]          = l;
        bus4.in_valid[ch]         = v;
    endtask

    // One clock of the 4-channel DUT: check ready before the edge, step the
    // model at the edge, check the output register just after it.
    task automatic cycle4();
        bit          granted;
        bit          can;
        bit          acc;
        int          g;
        logic [15:0] d;
        logic        l;
        @(negedge clk);
        can     = !m_ov || (bus4.out_ready === 1'b1);
        granted = 1'b0;
        g       = 0;
        if (m_lock) begin
            granted = 1'b1;
            g       = m_gnt;
        end else begin
            for (int k = 0; k < N4; k++) begin
                if (!granted && bus4.in_valid[(m_ptr + k) % N4]) begin
                    granted = 1'b1;
                    g       = (m_ptr + k) % N4;
                end
            end
        end
        check("in_ready", 32'(bus4.in_ready), (granted && can) ? (32'd1 << g) : 32'd0);
        acc = granted && can && (bus4.in_valid[g] === 1'b1);
        d   = bus4.in_data[g*16 +: 16];
        l   = bus4.in_last[g];
        @(posedge clk);
        if (acc) begin
            m_ov = 1'b1; m_od = d; m_ol = l; m_oc = g;
            if (l) begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % N4;
            end else begin
                m_lock = 1'b1;
                m_gnt  = g;
            end
        end else if (bus4.out_ready) begin
            m_ov = 1'b0;
        end
        #1;
        check("out_valid", 32'(bus4.out_valid), 32'(m_ov));
        check("out_data",  32'(bus4.out_data),  32'(m_od));
        check("out_last",  32'(bus4.out_last),  32'(m_ol));
        check("out_chan",  32'(bus4.out_chan),  32'(m_oc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_exp;
        int          tx;
        int          rx;
        bit          fire_in;
        bit          fire_out;

        bus4.in_data = '0; bus4.in_last = '0; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        bus1.in_data = '0; bus1.in_last = '0; bus1.in_valid = '0;   bus1.out_ready = 1'b0;
        model_reset();

        // Reset: everything low, no ready even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_out_data",  32'(bus4.out_data),  32'd0);
        check("rst_out_last",  32'(bus4.out_last),  32'd0);
        check("rst_out_chan",  32'(bus4.out_chan),  32'd0);
        check("rst_in_ready",  32'(bus4.in_ready),  32'd0);
        bus4.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single channel: ch2 wins alone, pointer moves to 3.
        set_ch(2, 16'hBEEF, 1'b1, 1'b1);
        cycle4();
        check("single_valid", 32'(bus4.out_valid), 32'd1);
        check("single_data",  32'(bus4.out_data),  32'h0000BEEF);
        check("single_chan",  32'(bus4.out_chan),  32'd2);
        bus4.in_valid = '0;
        cycle4();

        // Round robin with every channel requesting single beats: 3,0,1,2,3,0.
        bus4.in_last  = 4'hF;
        bus4.in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            bus4.in_data = {$urandom(), $urandom()};
            cycle4();
            check("rr_valid", 32'(bus4.out_valid), 32'd1);
            check("rr_chan",  32'(bus4.out_chan),  32'((3 + i) % 4));
        end

        // Burst lock: ch1 three beats while ch0 keeps requesting, then ch0.
        bus4.in_valid = 4'b0011;
        bus4.in_last  = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus4.in_last[1] = 1'b1;
            bus4.in_data = {$urandom(), $urandom()};
            cycle4();
            check("burst_chan", 32'(bus4.out_chan), 32'd1);
        end
        bus4.in_valid = 4'b0001;
        cycle4();
        check("burst_next_chan", 32'(bus4.out_chan), 32'd0);

        // Backpressure: output frozen, no channel ready; then one beat per cycle.
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 4'hF;
        bus4.in_last   = 4'hF;
        hold_exp       = m_od;
        for (int i = 0; i < 5; i++) begin
            bus4.in_data = {$urandom(), $urandom()};
            cycle4();
            check("bp_in_ready", 32'(bus4.in_ready), 32'd0);
            check("bp_hold",     32'(bus4.out_data), 32'(hold_exp));
        end
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle4();
            check("bp_drain_valid", 32'(bus4.out_valid), 32'd1);
            check("bp_drain_chan",  32'(bus4.out_chan),  32'((1 + i) % 4));
        end
        bus4.in_valid = '0;
        cycle4();

        // Burst bubble on ch3, then reset in the middle of the burst.
        bus4.in_valid = 4'b1000;
        bus4.in_last  = 4'b0111;
        cycle4();
        check("bub_first_chan", 32'(bus4.out_chan), 32'd3);
        bus4.in_valid = 4'b0111;
        repeat (2) cycle4();
        check("bub_no_beat", 32'(bus4.out_valid), 32'd0);
        check("bub_ready",   32'(bus4.in_ready),  32'b1000);
        bus4.in_valid = 4'b1000;
        cycle4();
        check("bub_resume_chan", 32'(bus4.out_chan), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    32'(bus4.out_valid), 32'd0);
        check("midrst_data",     32'(bus4.out_data),  32'd0);
        check("midrst_chan",     32'(bus4.out_chan),  32'd0);
        check("midrst_in_ready", 32'(bus4.in_ready),  32'd0);
        model_reset();
        bus4.in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 4'hF;
        bus4.in_last  = 4'hF;
        cycle4();
        check("post_rst_chan", 32'(bus4.out_chan), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus4.in_valid  = 4'($urandom_range(0, 15));
            bus4.in_last   = 4'($urandom_range(0, 15));
            bus4.in_data   = {$urandom(), $urandom()};
            bus4.out_ready = ($urandom_range(0, 3) != 0);
            cycle4();
        end
        bus4.in_valid  = '0;
        bus4.out_ready = 1'b1;
        cycle4();

        // N=1 stream 0..255, bursts of four, random downstream ready.
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 4000 && rx < 256; cyc++) begin
            bus1.out_ready = 1'($urandom_range(0, 1));
            bus1.in_valid  = (tx < 256) ? 1'b1 : 1'b0;
            bus1.in_data   = 8'(tx);
            bus1.in_last   = (tx % 4 == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            fire_in  = (bus1.in_valid[0] === 1'b1) && (bus1.in_ready[0] === 1'b1);
            fire_out = (bus1.out_valid === 1'b1) && (bus1.out_ready === 1'b1);
            if (fire_out) begin
                check("n1_data", 32'(bus1.out_data), 32'(rx % 256));
                check("n1_last", 32'(bus1.out_last), (rx % 4 == 3) ? 32'd1 : 32'd0);
                check("n1_chan", 32'(bus1.out_chan), 32'd0);
                rx++;
            end
            @(posedge clk);
            #1;
            if (fire_in) tx++;
        end
        check("n1_count", 32'(rx), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
